// File: rtl/adv_pkg.sv
// rtl/adv_pkg.sv - shared types and lamp constants for the adv_multi signal sequencer
// Contents: adv_state_t controller states, lamp bit positions, served-channel lamp decode.
package adv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } adv_state_t;

    // Bit positions within a per-channel {red, yel, grn} lamp triple.
    localparam int LAMP_GRN = 0;
    localparam int LAMP_YEL = 1;
    localparam int LAMP_RED = 2;

    // One-hot lamp triple shown by the served channel in a given state.
    function automatic logic [2:0] lamp_code(input adv_state_t s);
        logic [2:0] c;
        c = '0;
        case (s)
            GREEN:   c[LAMP_GRN] = 1'b1;
            YELLOW:  c[LAMP_YEL] = 1'b1;
            default: c[LAMP_RED] = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/adv_timer.sv
// rtl/adv_timer.sv - loadable down-counter timing the green, yellow and all-red intervals
// Ports: clk, rst_n (async active-low), load/load_val (reload counter), expired (counter is zero).
module adv_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter parks at zero, so a state waiting past expiry keeps seeing expired=1.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/adv_multi.sv
// rtl/adv_multi.sv - round-robin multi-channel traffic-signal sequencer
// Ports: clk, rst_n (async active-low), start (run enable), req (per-channel demand, only with
// ADV_SKIP_EN), grn/yel/red (per-channel lamps), ch_idx (served channel), busy (not idle).
// Build option: ADV_SKIP_EN adds req and skips channels without demand.
module adv_multi
    import adv_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int GREEN_CYC  = 5,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
`ifdef ADV_SKIP_EN
    input  logic [NUM_CH-1:0]         req,
`endif
    output logic [NUM_CH-1:0]         grn,
    output logic [NUM_CH-1:0]         yel,
    output logic [NUM_CH-1:0]         red,
    output logic [$clog2(NUM_CH)-1:0] ch_idx,
    output logic                      busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);

    logic [NUM_CH-1:0] dem;
`ifdef ADV_SKIP_EN
    assign dem = req;
`else
    // Every channel always has demand, which reduces the search to plain round-robin.
    assign dem = '1;
`endif

    // First channel with demand searched cyclically from cur+1; cur itself is checked last.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] cur,
                                                input logic [NUM_CH-1:0] r);
        logic [CH_W-1:0] res;
        logic [CH_W:0]   sum;
        logic            found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            sum = {1'b0, cur} + (CH_W + 1)'(i);
            if (sum >= (CH_W + 1)'(NUM_CH)) begin
                sum = sum - (CH_W + 1)'(NUM_CH);
            end
            if (!found && r[sum[CH_W-1:0]]) begin
                found = 1'b1;
                res   = sum[CH_W-1:0];
            end
        end
        return res;
    endfunction

    adv_state_t        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] grn_q, grn_d, yel_q, yel_d, red_q, red_d;
    logic              busy_q, busy_d;
    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              expired;
    logic [2:0]        lc;

    adv_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE: begin
                // Searching from the last channel makes the first hit the lowest demand bit.
                if (start && (|dem)) begin
                    state_d  = GREEN;
                    ch_d     = next_ch(CH_W'(NUM_CH - 1), dem);
                    load     = 1'b1;
                    load_val = GREEN_LD;
                end
            end
            GREEN: begin
                if (expired) begin
                    state_d  = YELLOW;
                    load     = 1'b1;
                    load_val = YELLOW_LD;
                end
            end
            YELLOW: begin
                if (expired) begin
                    state_d  = ALLRED;
                    load     = 1'b1;
                    load_val = ALLRED_LD;
                end
            end
            default: begin
                // With no demand, hold all-red with the counter parked at zero.
                if (expired) begin
                    if (!start) begin
                        state_d = IDLE;
                    end else if (|dem) begin
                        state_d  = GREEN;
                        ch_d     = next_ch(ch_q, dem);
                        load     = 1'b1;
                        load_val = GREEN_LD;
                    end
                end
            end
        endcase
    end

    // Lamps and busy are decoded from the current state and registered, so they trail it by a cycle.
    always_comb begin
        grn_d  = '0;
        yel_d  = '0;
        red_d  = '1;
        busy_d = (state_q != IDLE);
        lc     = lamp_code(state_q);
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == ch_q) begin
                grn_d[c] = lc[LAMP_GRN];
                yel_d[c] = lc[LAMP_YEL];
                red_d[c] = lc[LAMP_RED];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            grn_q   <= '0;
            yel_q   <= '0;
            red_q   <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            grn_q   <= grn_d;
            yel_q   <= yel_d;
            red_q   <= red_d;
            busy_q  <= busy_d;
        end
    end

    assign grn    = grn_q;
    assign yel    = yel_q;
    assign red    = red_q;
    assign ch_idx = ch_q;
    assign busy   = busy_q;

endmodule
